aes_round_seq: RTL and testbench
================================

# aes_round_seq

Multi-cycle sequencer that executes one full AES round on a 128-bit state by time-multiplexing a single shared 32-bit combinational AES unit (SubBytes / MixColumns, forward or inverse). It sits between the core's AES coprocessor register file and the shared unit. The block accepts a state and round key, drives the unit column by column, applies ShiftRows / InvShiftRows and AddRoundKey internally, and returns the new state with a done pulse.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- inv_in  in  1  0 = encrypt round, 1 = decrypt round
- last_in  in  1  1 = final round (MixColumns step skipped)
- state_in  in  128  input state; byte i at bits [8i+7:8i]; byte i is row i%4, column i/4
- rkey  in  128  round key, same byte order; sampled at start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; state_out valid in the same cycle
- state_out  out  128  registered result; holds until the next done
- u_sub, u_mix, u_inv  out  1 each  shared-unit op selects
- u_a, u_b  out  32 each  shared-unit operands
- u_c  in  32  shared-unit result, combinational from u_*

## Operation
- Registers: st[127:0], tmp[127:0], key[127:0], inv_r, last_r, cnt[1:0], FSM state.
- FSM states: IDLE, SUB, MIX, ARK, FIN.
- IDLE: on start, latch st<=state_in, key<=rkey, inv_r, last_r, cnt<=0, go to SUB.
- Operand rule: u_a = u_b = column cnt of the working word (st for SUB, tmp for MIX). Identical operands make every unit byte lane act on the same column.
- SUB: u_sub=1, u_inv=inv_r. Each cycle, tmp column cnt <= u_c and cnt increments. After cnt=3, tmp <= ShiftRows(tmp) if inv_r=0, InvShiftRows(tmp) if inv_r=1. ShiftRows means out(r,c)=in(r,(c+r)%4); InvShiftRows means out(r,c)=in(r,(c-r)%4).
- SUB transitions: encrypt with last_r=0 -> MIX. Encrypt with last_r=1 -> ARK. Decrypt -> ARK in both cases.
- MIX: u_mix=1, u_inv=inv_r, operand from tmp. Each cycle, tmp column cnt <= u_c. After cnt=3: encrypt -> ARK, decrypt -> FIN.
- ARK: tmp <= tmp ^ key, one cycle. Encrypt -> FIN. Decrypt with last_r=0 -> MIX (cnt=0). Decrypt with last_r=1 -> FIN.
- Resulting step order: encrypt = S, SR, M, ARK. Decrypt = IS, ISR, ARK, IM. M / IM are omitted when last_r=1.
- FIN: state_out <= tmp, done=1, then IDLE.
- When not in SUB/MIX, u_sub=u_mix=u_inv=0 and u_a=u_b=0, so the unit sees a quiet bus.
- start is ignored while not in IDLE. There is no queuing.
- Arithmetic is XOR only. cnt wraps 3->0 on every phase exit.

## Timing
- Reset values: busy=0, done=0, state_out=0, u_*=0, FSM=IDLE, cnt=0, all internal registers 0.
- Start accepted at edge E. busy is high from E through the cycle done is high. done falls on the next edge.
- Latency from start edge to done cycle: 10 cycles when last_r=0 (4 SUB + 4 MIX + 1 ARK + FIN). 6 cycles when last_r=1.
- start asserted in the same cycle as done: ignored, because the FSM is in FIN. The first accepted restart is the next cycle, and back-to-back throughput is one round per 11 cycles.
- rst_n low mid-round aborts immediately. All outputs return to reset values asynchronously, and no done is issued for the aborted round.
- state_in and rkey may change after the start edge without affecting the result.
- u_* outputs are combinational from FSM and cnt. u_c is sampled at the same edge, so the shared unit must settle in one cycle.

## Test plan
- Encrypt, last_in=0. state_in = bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08; rkey = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05. Required: done exactly 10 cycles later with state_out = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49.
- Encrypt, last_in=1. state_in = eb 40 f2 1e 59 2e 38 84 8b a1 13 e7 1b c3 42 d2; rkey = d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6. Required: done after 6 cycles with state_out = 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Round trip, rkey=0. Run encrypt-last on X = 00 01 … 0f, feed the result to decrypt-last. Required: state_out = X. Also, u_mix is never asserted in either run.
- Decrypt, last_in=0, random state and key, 1000 iterations. Required: matches the software model IM(IS(ISR(s)) ^ k), 10-cycle latency, and the u_a/u_b column sequence 0,1,2,3 in both SUB and MIX.
- start pulsed in every cycle of a round, including the done cycle. Required: exactly one done per 11 cycles, busy never drops mid-round, and inputs changed after acceptance do not alter the result.
- rst_n asserted during MIX, cnt=2. Required: all outputs 0 asynchronously, and no done pulse. A fresh start after release completes with the correct result and 10-cycle latency.

Source files
------------

// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - one AES round sequenced over a shared 32-bit SubBytes/MixColumns unit
//
// Executes a full AES round (forward or inverse) on a 128-bit state by feeding
// one column per cycle through an external combinational 32-bit unit that does
// SubBytes or MixColumns. ShiftRows/InvShiftRows and AddRoundKey are done here.
//
// Step order: encrypt = S, SR, M, ARK ; decrypt = IS, ISR, ARK, IM.
// M / IM are skipped on the final round.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      round request, sampled only while idle
//   inv_in     0 = encrypt round, 1 = decrypt round
//   last_in    1 = final round (no MixColumns step)
//   state_in   input state, byte i at [8i+7:8i], row i%4, column i/4
//   rkey       round key, same byte order, sampled with start
//   busy       high from the cycle after start is accepted through the done cycle
//   done       one-cycle pulse, state_out valid in that cycle
//   state_out  registered result, held until the next done
//   u_sub      shared unit: SubBytes select
//   u_mix      shared unit: MixColumns select
//   u_inv      shared unit: inverse-operation select
//   u_a, u_b   shared unit operands (always the same column)
//   u_c        shared unit result, combinational from the u_* outputs

module aes_round_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         inv_in,
  input  logic         last_in,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic         u_sub,
  output logic         u_mix,
  output logic         u_inv,
  output logic [31:0]  u_a,
  output logic [31:0]  u_b,
  input  logic [31:0]  u_c
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB,
    S_MIX,
    S_ARK,
    S_FIN
  } fsm_t;

  fsm_t         fsm;
  logic [127:0] st;
  logic [127:0] tmp;
  logic [127:0] key;
  logic         inv_r;
  logic         last_r;
  logic [1:0]   cnt;

  logic [127:0] work;
  logic [31:0]  col_sel;
  logic [127:0] tmp_upd;
  logic [127:0] tmp_ark;

  // Column idx (0..3) of a 128-bit state.
  function automatic logic [31:0] get_col(input logic [127:0] w, input logic [1:0] idx);
    logic [31:0] c;
    c = '0;
    case (idx)
      2'd0: c = w[31:0];
      2'd1: c = w[63:32];
      2'd2: c = w[95:64];
      2'd3: c = w[127:96];
      default: c = '0;
    endcase
    return c;
  endfunction

  // Forward: out(r,c) = in(r,(c+r)%4). Inverse: out(r,c) = in(r,(c-r)%4).
  // The 2-bit column index wraps modulo 4 for free.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c - r) : 2'(c + r);
        o[8*(4*c+r) +: 8] = s[8*(4*int'(src)+r) +: 8];
      end
    end
    return o;
  endfunction

  // SUB works on the latched input state, MIX on the partially built result.
  assign work    = (fsm == S_SUB) ? st : tmp;
  assign col_sel = get_col(work, cnt);
  assign tmp_ark = tmp ^ key;

  // tmp with the current column replaced by the unit result.
  always_comb begin
    tmp_upd = tmp;
    case (cnt)
      2'd0: tmp_upd[31:0]   = u_c;
      2'd1: tmp_upd[63:32]  = u_c;
      2'd2: tmp_upd[95:64]  = u_c;
      2'd3: tmp_upd[127:96] = u_c;
      default: tmp_upd = tmp;
    endcase
  end

  // Shared-unit bus is quiet (all zero) outside the SUB and MIX phases.
  always_comb begin
    u_sub = 1'b0;
    u_mix = 1'b0;
    u_inv = 1'b0;
    u_a   = '0;
    case (fsm)
      S_SUB: begin
        u_sub = 1'b1;
        u_inv = inv_r;
        u_a   = col_sel;
      end
      S_MIX: begin
        u_mix = 1'b1;
        u_inv = inv_r;
        u_a   = col_sel;
      end
      default: begin
        u_sub = 1'b0;
      end
    endcase
  end

  // Identical operands make every byte lane of the unit act on one column.
  assign u_b = u_a;

  // done and state_out are loaded on the edge that enters FIN so that the
  // result is already valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      st        <= '0;
      tmp       <= '0;
      key       <= '0;
      inv_r     <= 1'b0;
      last_r    <= 1'b0;
      cnt       <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            st     <= state_in;
            key    <= rkey;
            inv_r  <= inv_in;
            last_r <= last_in;
            cnt    <= 2'd0;
            busy   <= 1'b1;
            fsm    <= S_SUB;
          end
        end

        S_SUB: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            tmp <= shift_rows(tmp_upd, inv_r);
            if (!inv_r && !last_r) begin
              fsm <= S_MIX;
            end else begin
              fsm <= S_ARK;
            end
          end else begin
            tmp <= tmp_upd;
          end
        end

        S_MIX: begin
          cnt <= cnt + 2'd1;
          tmp <= tmp_upd;
          if (cnt == 2'd3) begin
            if (inv_r) begin
              state_out <= tmp_upd;
              done      <= 1'b1;
              fsm       <= S_FIN;
            end else begin
              fsm <= S_ARK;
            end
          end
        end

        S_ARK: begin
          tmp <= tmp_ark;
          if (inv_r && !last_r) begin
            // cnt already wrapped to 0 on SUB exit.
            fsm <= S_MIX;
          end else begin
            state_out <= tmp_ark;
            done      <= 1'b1;
            fsm       <= S_FIN;
          end
        end

        S_FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end

        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - directed and randomised self-checking bench for aes_round_seq

module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         inv_in = 1'b0;
  logic         last_in = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] rkey = '0;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         u_sub;
  logic         u_mix;
  logic         u_inv;
  logic [31:0]  u_a;
  logic [31:0]  u_b;
  logic [31:0]  u_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_round_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inv_in    (inv_in),
    .last_in   (last_in),
    .state_in  (state_in),
    .rkey      (rkey),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .u_sub     (u_sub),
    .u_mix     (u_mix),
    .u_inv     (u_inv),
    .u_a       (u_a),
    .u_b       (u_b),
    .u_c       (u_c)
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, r;
    x = a; y = b; r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return r;
  endfunction

  // x^254 = multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox_f(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int j);
    logic [7:0] c;
    case (j)
      0: c = inv ? 8'h0e : 8'h02;
      1: c = inv ? 8'h0b : 8'h03;
      2: c = inv ? 8'h0d : 8'h01;
      default: c = inv ? 8'h09 : 8'h01;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] mixcol_w(input logic [31:0] w, input logic inv);
    logic [31:0] o;
    logic [7:0]  acc;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int i = 0; i < 4; i++) acc = acc ^ gmul(coef(inv, (i - r + 4) % 4), w[8*i +: 8]);
      o[8*r +: 8] = acc;
    end
    return o;
  endfunction

  function automatic logic [127:0] sub_m(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv ? isbox_f(s[8*i +: 8]) : sbox_f(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_m(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*src) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mixcol_w(s[32*c +: 32], inv);
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    t = shift_m(sub_m(s, 1'b0), 1'b0);
    if (!last) t = mix_m(t, 1'b0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    t = shift_m(sub_m(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_m(t, 1'b1);
    return t;
  endfunction

  // Byte string written first-byte-first in a literal -> byte i at [8i+7:8i].
  function automatic logic [127:0] from_fips(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127 - 8*i -: 8];
    return o;
  endfunction

  function automatic logic [31:0] col_of(input logic [127:0] x, input int i);
    return x[32*i +: 32];
  endfunction

  // Shared combinational unit seen by the DUT.
  function automatic logic [31:0] unit_model(input logic sub, input logic mix, input logic inv, input logic [31:0] a);
    logic [31:0] o;
    o = '0;
    if (sub) begin
      for (int i = 0; i < 4; i++) o[8*i +: 8] = inv ? isbox_f(a[8*i +: 8]) : sbox_f(a[8*i +: 8]);
    end else if (mix) begin
      o = mixcol_w(a, inv);
    end
    return o;
  endfunction

  assign u_c = unit_model(u_sub, u_mix, u_inv, u_a);

  // ---------------- stimulus helper ----------------
  // Drives one round and records what it observed; callers do the comparisons.
  task automatic run_round(input logic [127:0] s, input logic [127:0] k, input logic inv, input logic last,
                           input logic [127:0] mw, output logic [127:0] res, output int lat,
                           output int n_sub, output int n_mix, output int col_err, output int busy_err);
    @(negedge clk);
    state_in = s; rkey = k; inv_in = inv; last_in = last; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; state_in = ~s; rkey = ~k; inv_in = ~inv; last_in = ~last;
    lat = 0; n_sub = 0; n_mix = 0; col_err = 0; busy_err = 0; res = '0;
    for (int cyc = 1; cyc <= 30 && lat == 0; cyc++) begin
      @(negedge clk);
      if (u_sub === 1'b1) begin
        if (n_sub > 3 || u_a !== col_of(s, n_sub) || u_b !== u_a || u_inv !== inv) col_err++;
        n_sub++;
      end
      if (u_mix === 1'b1) begin
        if (n_mix > 3 || u_a !== col_of(mw, n_mix) || u_b !== u_a || u_inv !== inv) col_err++;
        n_mix++;
      end
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        lat = cyc;
        res = state_out;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    end
    checks++;
    if (state_out !== 128'h0) begin
      failures++; $display("FAIL reset_state_out got=%h exp=0", state_out);
    end
    checks++;
    if ({u_sub, u_mix, u_inv, u_a, u_b} !== 67'h0) begin
      failures++; $display("FAIL reset_unit_bus got=%b%b%b %h %h exp=all zero", u_sub, u_mix, u_inv, u_a, u_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    logic [127:0] s, k, exp, res;
    int lat, ns, nm, ce, be;
    s   = from_fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    k   = from_fips(128'ha0fafe1788542cb123a339392a6c7605);
    exp = from_fips(128'ha49c7ff2689f352b6b5bea43026a5049);
    run_round(s, k, 1'b0, 1'b0, shift_m(sub_m(s, 1'b0), 1'b0), res, lat, ns, nm, ce, be);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL enc_latency got=%0d exp=10", lat); end
    checks++;
    if (res !== exp) begin failures++; $display("FAIL enc_result got=%h exp=%h", res, exp); end
    checks++;
    if (ns !== 4 || nm !== 4 || ce !== 0) begin
      failures++; $display("FAIL enc_columns sub=%0d mix=%0d col_err=%0d exp 4 4 0", ns, nm, ce);
    end
    checks++;
    if (be !== 0) begin failures++; $display("FAIL enc_busy drops=%0d exp=0", be); end
  endtask

  task automatic test_encrypt_last();
    logic [127:0] s, k, exp, res;
    int lat, ns, nm, ce, be;
    s   = from_fips(128'heb40f21e592e38848ba113e71bc342d2);
    k   = from_fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    exp = from_fips(128'h3925841d02dc09fbdc118597196a0b32);
    run_round(s, k, 1'b0, 1'b1, 128'h0, res, lat, ns, nm, ce, be);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL enc_last_latency got=%0d exp=6", lat); end
    checks++;
    if (res !== exp) begin failures++; $display("FAIL enc_last_result got=%h exp=%h", res, exp); end
    checks++;
    if (ns !== 4 || nm !== 0 || ce !== 0 || be !== 0) begin
      failures++; $display("FAIL enc_last_bus sub=%0d mix=%0d col_err=%0d busy_err=%0d exp 4 0 0 0", ns, nm, ce, be);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] x, r1, r2;
    int lat1, lat2, ns, nm1, nm2, ce, be;
    x = from_fips(128'h000102030405060708090a0b0c0d0e0f);
    run_round(x, 128'h0, 1'b0, 1'b1, 128'h0, r1, lat1, ns, nm1, ce, be);
    run_round(r1, 128'h0, 1'b1, 1'b1, 128'h0, r2, lat2, ns, nm2, ce, be);
    checks++;
    if (r2 !== x) begin failures++; $display("FAIL round_trip got=%h exp=%h", r2, x); end
    checks++;
    if (nm1 !== 0 || nm2 !== 0) begin
      failures++; $display("FAIL round_trip_no_mix enc=%0d dec=%0d exp 0 0", nm1, nm2);
    end
    checks++;
    if (lat1 !== 6 || lat2 !== 6) begin
      failures++; $display("FAIL round_trip_latency enc=%0d dec=%0d exp 6 6", lat1, lat2);
    end
  endtask

  task automatic test_decrypt_random();
    logic [127:0] s, k, exp, res;
    int lat, ns, nm, ce, be;
    for (int it = 0; it < 1000; it++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      exp = dec_round(s, k, 1'b0);
      run_round(s, k, 1'b1, 1'b0, shift_m(sub_m(s, 1'b1), 1'b1) ^ k, res, lat, ns, nm, ce, be);
      checks++;
      if (res !== exp) begin failures++; $display("FAIL dec_result it=%0d got=%h exp=%h", it, res, exp); end
      checks++;
      if (lat !== 10) begin failures++; $display("FAIL dec_latency it=%0d got=%0d exp=10", it, lat); end
      checks++;
      if (ns !== 4 || nm !== 4 || ce !== 0 || be !== 0) begin
        failures++;
        $display("FAIL dec_columns it=%0d sub=%0d mix=%0d col_err=%0d busy_err=%0d exp 4 4 0 0", it, ns, nm, ce, be);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] in_s [0:32];
    logic [127:0] in_k [0:32];
    logic exp_busy, exp_done, acc;
    int n_done;
    n_done = 0;
    for (int t = 0; t <= 32; t++) begin
      @(negedge clk);
      exp_done = (t == 10 || t == 21 || t == 32);
      exp_busy = !(t == 0 || t == 11 || t == 22);
      acc      = (t == 0 || t == 11 || t == 22);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        failures++; $display("FAIL b2b_handshake t=%0d done=%b busy=%b exp %b %b", t, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        n_done++;
        checks++;
        if (state_out !== enc_round(in_s[t-10], in_k[t-10], 1'b0)) begin
          failures++;
          $display("FAIL b2b_result t=%0d got=%h exp=%h", t, state_out, enc_round(in_s[t-10], in_k[t-10], 1'b0));
        end
      end
      in_s[t]  = {$urandom, $urandom, $urandom, $urandom};
      in_k[t]  = {$urandom, $urandom, $urandom, $urandom};
      state_in = in_s[t];
      rkey     = in_k[t];
      inv_in   = acc ? 1'b0 : 1'($urandom_range(0, 1));
      last_in  = acc ? 1'b0 : 1'($urandom_range(0, 1));
      start    = (t < 32);
    end
    start = 1'b0;
    checks++;
    if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", n_done); end
  endtask

  task automatic test_abort();
    logic [127:0] s, k, res;
    int lat, ns, nm, ce, be, bad;
    s = from_fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    k = from_fips(128'ha0fafe1788542cb123a339392a6c7605);
    @(negedge clk);
    state_in = s; rkey = k; inv_in = 1'b0; last_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) @(negedge clk);
    checks++;
    if (u_mix !== 1'b1 || u_a !== col_of(shift_m(sub_m(s, 1'b0), 1'b0), 2)) begin
      failures++; $display("FAIL abort_in_mix2 u_mix=%b u_a=%h", u_mix, u_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, u_sub, u_mix, u_inv, u_a, u_b} !== 69'h0 || state_out !== 128'h0) begin
      failures++;
      $display("FAIL abort_async_clear busy=%b done=%b unit=%b%b%b %h %h out=%h exp all zero",
               busy, done, u_sub, u_mix, u_inv, u_a, u_b, state_out);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL abort_no_done bad_cycles=%0d exp=0", bad); end
    run_round(s, k, 1'b0, 1'b0, shift_m(sub_m(s, 1'b0), 1'b0), res, lat, ns, nm, ce, be);
    checks++;
    if (lat !== 10 || res !== from_fips(128'ha49c7ff2689f352b6b5bea43026a5049)) begin
      failures++; $display("FAIL abort_restart lat=%0d got=%h exp lat 10 a49c7ff2...", lat, res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encrypt();
    test_encrypt_last();
    test_round_trip();
    test_decrypt_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
